// File: rtl/seq_reg_share_arbiter.sv
// Round-robin arbiter that grants one requester at a time ownership of a shared
// WIDTH-bit register, loading one beat per cycle up to a burst cap.
module seq_reg_share_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         last,
    input  logic [NUM_REQ*WIDTH-1:0]   data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid
);

    localparam int unsigned OWNER_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [OWNER_W-1:0]   ptr, ptr_n;
    logic [OWNER_W-1:0]   owner_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [NUM_REQ-1:0]   gnt_n;
    logic                 busy_n;
    logic [WIDTH-1:0]     q_n;
    logic                 q_valid_n;

    logic                 found;
    logic [OWNER_W-1:0]   win;
    logic [OWNER_W-1:0]   idx;
    logic [WIDTH-1:0]     data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = data[i*WIDTH +: WIDTH];
    end

    // First active request searching upward from ptr+1 with wrap-around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = OWNER_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        cnt_n     = cnt;
        gnt_n     = gnt;
        busy_n    = busy;
        q_n       = q;
        q_valid_n = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    state_n = OWN;
                    gnt_n   = NUM_REQ'(1) << win;
                    owner_n = win;
                    ptr_n   = win;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            OWN: begin
                if (req[owner]) begin
                    q_n       = data_arr[owner];
                    q_valid_n = 1'b1;
                    cnt_n     = cnt + CNT_W'(1);
                    if (last[owner] || (cnt_n == CNT_W'(MAX_BURST))) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        busy_n  = 1'b0;
                    end
                end else begin
                    // Owner dropped its request: abandon without a load.
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= OWNER_W'(NUM_REQ - 1);
            owner   <= '0;
            cnt     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            owner   <= owner_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            busy    <= busy_n;
            q       <= q_n;
            q_valid <= q_valid_n;
        end
    end

endmodule
